// File: rtl/result_pkg.sv
// result_pkg
// Shared constants for the result/commit stage: the 3-bit instruction
// opcodes decoded by the commit FSM and the FSM state encoding, which is
// also exported on the state_dbg port.
package result_pkg;

  // Opcodes
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ALU   = 3'b001;
  localparam logic [2:0] OP_JUMP  = 3'b010;
  localparam logic [2:0] OP_JR    = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_JAL   = 3'b110;
  localparam logic [2:0] OP_BCOND = 3'b111;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_BRANCH = 3'd2;
  localparam logic [2:0] ST_MEM_RD = 3'd3;
  localparam logic [2:0] ST_MEM_WR = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

endpackage

// File: rtl/result_mem_port.sv
// result_mem_port
// Data-memory side of the commit stage. While the commit FSM sits in a
// memory state this block raises mem_req one cycle later, holds it until
// mem_ack or until TIMEOUT request cycles have elapsed, and latches load
// data on the acknowledging edge.
//
// Ports:
//   CLOCK_50, resetIn  clock, asynchronous active-low reset
//   active             FSM is in MEM_RD or MEM_WR
//   is_write           FSM is in MEM_WR
//   mem_ack, mem_rdata memory response (rdata valid with ack)
//   mem_req, mem_we    registered memory request / write strobe
//   done               comb pulse: ack seen on this edge
//   timeout            comb pulse: request expires on this edge
//   rdata_q            load data captured at the ack edge
module result_mem_port #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLOCK_50,
  input  logic              resetIn,
  input  logic              active,
  input  logic              is_write,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] rdata_q
);

  // The counter holds the number of completed request cycles without ack;
  // the request expires on the edge that would bring it to TIMEOUT.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;

  // An ack arriving on the expiring cycle takes priority: success wins.
  assign done    = active && mem_req && mem_ack;
  assign timeout = active && mem_req && !mem_ack && (wait_cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge resetIn) begin
    if (!resetIn) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      wait_cnt <= '0;
      rdata_q  <= '0;
    end else if (!active) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      wait_cnt <= '0;
    end else if (!mem_req) begin
      // First cycle of a memory state: launch the request.
      mem_req  <= 1'b1;
      mem_we   <= is_write;
      wait_cnt <= '0;
    end else if (mem_ack) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      rdata_q <= mem_rdata;
    end else if (timeout) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/result_commit_unit.sv
// result_commit_unit
// Result/commit stage of the multi-cycle MIPS-style core. Accepts one
// decoded instruction per four-phase enable/acknowledge handshake, computes
// the next PC, performs the data-memory access and issues at most one
// register-file write. All outputs come from registers.
//
// Ports:
//   CLOCK_50, resetIn             clock, asynchronous active-low reset
//   enable / acknowledge          four-phase request / completion
//   opCode, RDadd, ALUres, ADDout,
//   PCold, RDold                  instruction operands, captured on accept
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack, mem_rdata data-memory handshake
//   rf_we, rf_waddr, rf_wdata     register-file write port
//   PCnew                         next PC, valid while acknowledge=1
//   err                           last operation hit a memory timeout
//   state_dbg                     current FSM state
module result_commit_unit
  import result_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 11,
  parameter int REG_AW   = 5,
  parameter int PC_W     = 32,
  parameter int PC_INC   = 1,
  parameter int TIMEOUT  = 15,
  parameter int ZERO_REG = 1
) (
  input  logic              CLOCK_50,
  input  logic              resetIn,
  input  logic              enable,
  output logic              acknowledge,
  input  logic [2:0]        opCode,
  input  logic [REG_AW-1:0] RDadd,
  input  logic [DATA_W-1:0] ALUres,
  input  logic [PC_W-1:0]   ADDout,
  input  logic [PC_W-1:0]   PCold,
  input  logic [DATA_W-1:0] RDold,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [PC_W-1:0]   PCnew,
  output logic              err,
  output logic [2:0]        state_dbg
);

  logic [2:0]        state;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [PC_W-1:0]   add_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] rdold_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [PC_W-1:0]   pc_inc;
  logic              mem_done;
  logic              mem_timeout;
  logic [DATA_W-1:0] rdata_q;
  logic              rf_suppress;

  assign pc_inc      = pc_q + PC_W'(PC_INC);
  assign rf_suppress = (ZERO_REG != 0) && (rd_q == '0);
  assign mem_addr    = alu_q[ADDR_W-1:0];
  assign mem_wdata   = rdold_q;
  assign state_dbg   = state;

  result_mem_port #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_mem_port (
    .CLOCK_50  (CLOCK_50),
    .resetIn   (resetIn),
    .active    ((state == ST_MEM_RD) || (state == ST_MEM_WR)),
    .is_write  (state == ST_MEM_WR),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .done      (mem_done),
    .timeout   (mem_timeout),
    .rdata_q   (rdata_q)
  );

  always_ff @(posedge CLOCK_50 or negedge resetIn) begin
    if (!resetIn) begin
      state       <= ST_IDLE;
      acknowledge <= 1'b0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      PCnew       <= '0;
      err         <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      add_q       <= '0;
      pc_q        <= '0;
      rdold_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      // Outputs trail the state by one edge so none depends on inputs.
      acknowledge <= (state == ST_DONE);
      rf_we       <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Waiting for acknowledge to fall keeps a fast requester from
          // starting a new operation inside the old handshake.
          if (enable && !acknowledge) begin
            op_q    <= opCode;
            rd_q    <= RDadd;
            alu_q   <= ALUres;
            add_q   <= ADDout;
            pc_q    <= PCold;
            rdold_q <= RDold;
            err     <= 1'b0;
            state   <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          PCnew     <= pc_inc;
          wb_data_q <= alu_q;
          case (op_q)
            OP_NOP:   state <= ST_DONE;
            OP_ALU:   state <= ST_WB;
            OP_JUMP:  state <= ST_BRANCH;
            OP_JR: begin
              PCnew <= PC_W'(rdold_q);
              state <= ST_DONE;
            end
            OP_LOAD:  state <= ST_MEM_RD;
            OP_STORE: state <= ST_MEM_WR;
            OP_JAL: begin
              wb_data_q <= DATA_W'(pc_inc);
              state     <= ST_BRANCH;
            end
            default:  state <= alu_q[0] ? ST_BRANCH : ST_DONE;
          endcase
        end

        ST_BRANCH: begin
          PCnew <= add_q;
          state <= (op_q == OP_JAL) ? ST_WB : ST_DONE;
        end

        ST_MEM_RD, ST_MEM_WR: begin
          if (mem_done) begin
            state <= (state == ST_MEM_RD) ? ST_WB : ST_DONE;
          end else if (mem_timeout) begin
            err   <= 1'b1;
            state <= ST_DONE;
          end
        end

        ST_WB: begin
          rf_we    <= !rf_suppress;
          rf_waddr <= rd_q;
          rf_wdata <= (op_q == OP_LOAD) ? rdata_q : wb_data_q;
          state    <= ST_DONE;
        end

        ST_DONE: begin
          if (!enable) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_commit_unit.sv
// tb_result_commit_unit
// Drives directed and random instructions through two instances of the
// commit unit (ZERO_REG=1 and ZERO_REG=0). For each instruction the bench
// derives the expected PC, register write, error flag and per-path cycle
// timeline from the instruction semantics, then compares every output on
// every cycle of the operation.
module tb_result_commit_unit;
  import result_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int REG_AW = 5;
  localparam int PC_W   = 32;
  localparam int T      = 15;

  logic              CLOCK_50 = 1'b0;
  logic              resetIn  = 1'b0;
  logic              enable   = 1'b0;
  logic [2:0]        opCode   = '0;
  logic [REG_AW-1:0] RDadd    = '0;
  logic [DATA_W-1:0] ALUres   = '0;
  logic [PC_W-1:0]   ADDout   = '0;
  logic [PC_W-1:0]   PCold    = '0;
  logic [DATA_W-1:0] RDold    = '0;
  logic              mem_ack  = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic              acknowledge, mem_req, mem_we, rf_we, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, rf_wdata;
  logic [REG_AW-1:0] rf_waddr;
  logic [PC_W-1:0]   PCnew;
  logic [2:0]        state_dbg;

  logic              z0_acknowledge, z0_mem_req, z0_mem_we, z0_rf_we, z0_err;
  logic [ADDR_W-1:0] z0_mem_addr;
  logic [DATA_W-1:0] z0_mem_wdata, z0_rf_wdata;
  logic [REG_AW-1:0] z0_rf_waddr;
  logic [PC_W-1:0]   z0_PCnew;
  logic [2:0]        z0_state_dbg;

  result_commit_unit #(.ZERO_REG(1)) u_dut (
    .CLOCK_50(CLOCK_50), .resetIn(resetIn), .enable(enable), .acknowledge(acknowledge),
    .opCode(opCode), .RDadd(RDadd), .ALUres(ALUres), .ADDout(ADDout), .PCold(PCold),
    .RDold(RDold), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .PCnew(PCnew), .err(err),
    .state_dbg(state_dbg)
  );

  result_commit_unit #(.ZERO_REG(0)) u_dut_z0 (
    .CLOCK_50(CLOCK_50), .resetIn(resetIn), .enable(enable), .acknowledge(z0_acknowledge),
    .opCode(opCode), .RDadd(RDadd), .ALUres(ALUres), .ADDout(ADDout), .PCold(PCold),
    .RDold(RDold), .mem_req(z0_mem_req), .mem_we(z0_mem_we), .mem_addr(z0_mem_addr),
    .mem_wdata(z0_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_we(z0_rf_we),
    .rf_waddr(z0_rf_waddr), .rf_wdata(z0_rf_wdata), .PCnew(z0_PCnew), .err(z0_err),
    .state_dbg(z0_state_dbg)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  // Observations from the most recent operation, used by literal checks.
  logic [PC_W-1:0]   obs_pc;
  logic              obs_err;
  logic [DATA_W-1:0] obs_rf_data;
  logic [REG_AW-1:0] obs_rf_addr;
  logic [ADDR_W-1:0] obs_mem_addr;
  int                obs_rf_cnt, obs_z0_cnt, obs_req_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // One complete handshake. d = number of request cycles before mem_ack
  // (d >= T means the memory never answers). Called #1 after an edge with
  // both units idle and acknowledge low.
  task automatic run_op(input logic [2:0] op, input logic [REG_AW-1:0] rd,
                        input logic [DATA_W-1:0] alu, input logic [PC_W-1:0] add,
                        input logic [PC_W-1:0] pcold, input logic [DATA_W-1:0] rdold,
                        input int d, input logic [DATA_W-1:0] rdata, input bit hold);
    int ack_at, wb_at, req_end;
    bit is_mem, mem_ok, exp_err, in_req;
    logic [PC_W-1:0]   exp_pc;
    logic [DATA_W-1:0] exp_wdata;

    // Expected results from the instruction semantics and path latencies.
    is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    mem_ok    = (d < T);
    exp_pc    = pcold + 1;
    exp_wdata = alu;
    exp_err   = 1'b0;
    wb_at     = -1;
    req_end   = 0;
    ack_at    = 2;
    case (op)
      OP_NOP:  ack_at = 2;
      OP_ALU:  begin wb_at = 2; ack_at = 3; end
      OP_JUMP: begin exp_pc = add; ack_at = 3; end
      OP_JR:   begin exp_pc = rdold; ack_at = 2; end
      OP_LOAD: begin
        if (mem_ok) begin
          req_end = 3 + d; wb_at = 4 + d; ack_at = 5 + d; exp_wdata = rdata;
        end else begin
          req_end = 2 + T; ack_at = 3 + T; exp_err = 1'b1;
        end
      end
      OP_STORE: begin
        if (mem_ok) begin
          req_end = 3 + d; ack_at = 4 + d;
        end else begin
          req_end = 2 + T; ack_at = 3 + T; exp_err = 1'b1;
        end
      end
      OP_JAL:  begin exp_pc = add; wb_at = 3; ack_at = 4; exp_wdata = pcold + 1; end
      default: begin
        if (alu[0]) begin exp_pc = add; ack_at = 3; end
        else ack_at = 2;
      end
    endcase

    obs_rf_cnt = 0; obs_z0_cnt = 0; obs_req_cycles = 0;
    obs_mem_addr = '0; obs_rf_data = '0; obs_rf_addr = '0;

    opCode = op; RDadd = rd; ALUres = alu; ADDout = add; PCold = pcold; RDold = rdold;
    enable = 1'b1;
    tick();  // accept edge E0

    // Operands must have been captured: scramble the live inputs.
    opCode = 3'($urandom); RDadd = REG_AW'($urandom); ALUres = $urandom;
    ADDout = $urandom; PCold = $urandom; RDold = $urandom;
    enable = hold;

    for (int c = 0; ; c++) begin
      if (c > 0) tick();
      if (c > 40) begin
        check("cycle_budget", 64'(c), 64'(ack_at));
        break;
      end
      in_req = (c >= 2) && (c < req_end);
      check("acknowledge", acknowledge, c >= ack_at);
      check("z0_acknowledge", z0_acknowledge, c >= ack_at);
      check("mem_req", mem_req, in_req);
      if (in_req) begin
        obs_req_cycles++;
        obs_mem_addr = mem_addr;
        check("mem_we", mem_we, op == OP_STORE);
        check("mem_addr", mem_addr, alu[ADDR_W-1:0]);
        if (op == OP_STORE) check("mem_wdata", mem_wdata, rdold);
      end
      check("rf_we", rf_we, (c == wb_at) && (rd != 0));
      check("z0_rf_we", z0_rf_we, c == wb_at);
      if (rf_we) begin
        obs_rf_cnt++;
        obs_rf_addr = rf_waddr;
        obs_rf_data = rf_wdata;
      end
      if (z0_rf_we) obs_z0_cnt++;
      if (c == wb_at) begin
        check("z0_rf_waddr", z0_rf_waddr, rd);
        check("z0_rf_wdata", z0_rf_wdata, exp_wdata);
        if (rd != 0) begin
          check("rf_waddr", rf_waddr, rd);
          check("rf_wdata", rf_wdata, exp_wdata);
        end
      end

      // Memory responder for the cycle following this sample.
      mem_ack   = is_mem && mem_ok && (c == 2 + d);
      mem_rdata = mem_ack ? rdata : $urandom;

      if (c == ack_at) begin
        check("PCnew", PCnew, exp_pc);
        check("z0_PCnew", z0_PCnew, exp_pc);
        check("err", err, exp_err);
        obs_pc  = PCnew;
        obs_err = err;
        break;
      end
    end
    mem_ack = 1'b0;

    if (hold) begin
      // DONE persists while enable is held.
      for (int i = 0; i < 2; i++) begin
        tick();
        check("ack_hold", acknowledge, 1'b1);
        check("pc_hold", PCnew, exp_pc);
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!acknowledge && !z0_acknowledge) break;
    end
    check("ack_release", acknowledge, 1'b0);
    check("idle_state", state_dbg, ST_IDLE);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_acknowledge"}, acknowledge, 1'b0);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_rf_we"}, rf_we, 1'b0);
    check({tag, "_PCnew"}, PCnew, 0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_rf_waddr"}, rf_waddr, 0);
    check({tag, "_rf_wdata"}, rf_wdata, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  initial begin
    #5;
    check_reset_values("por");
    tick();
    resetIn = 1'b1;
    tick();

    // ALU write to r7
    run_op(OP_ALU, 5'd7, 32'hDEADBEEF, 32'h0, 32'h40, 32'h0, 0, 32'h0, 1'b1);
    check("alu_pc_lit", obs_pc, 32'h41);
    check("alu_rf_data_lit", obs_rf_data, 32'hDEADBEEF);
    check("alu_rf_addr_lit", obs_rf_addr, 5'd7);
    check("alu_rf_cnt_lit", obs_rf_cnt, 1);

    // Load after 3 wait cycles
    run_op(OP_LOAD, 5'd9, 32'h123, 32'h0, 32'h100, 32'h0, 3, 32'h55, 1'b1);
    check("load_addr_lit", obs_mem_addr, 11'h123);
    check("load_data_lit", obs_rf_data, 32'h55);
    check("load_err_lit", obs_err, 1'b0);
    check("load_req_cycles_lit", obs_req_cycles, 4);

    // Store that never gets an ack
    run_op(OP_STORE, 5'd3, 32'h7FF, 32'h0, 32'h200, 32'hCAFEF00D, 100, 32'h0, 1'b0);
    check("st_to_req_cycles_lit", obs_req_cycles, 15);
    check("st_to_err_lit", obs_err, 1'b1);
    check("st_to_rf_cnt_lit", obs_rf_cnt, 0);

    // Jump-and-link, then an untaken conditional branch
    run_op(OP_JAL, 5'd31, 32'h0, 32'h80, 32'h10, 32'h0, 0, 32'h0, 1'b1);
    check("jal_pc_lit", obs_pc, 32'h80);
    check("jal_link_lit", obs_rf_data, 32'h11);
    run_op(OP_BCOND, 5'd1, 32'h0, 32'h80, 32'h10, 32'h0, 0, 32'h0, 1'b0);
    check("bcond_nt_pc_lit", obs_pc, 32'h11);

    // Writes to r0: suppressed only when ZERO_REG=1
    run_op(OP_ALU, 5'd0, 32'h1234, 32'h0, 32'h20, 32'h0, 0, 32'h0, 1'b1);
    check("r0_rf_cnt_lit", obs_rf_cnt, 0);
    check("r0_z0_cnt_lit", obs_z0_cnt, 1);

    // Timeout boundary: ack on the expiring cycle succeeds, one later fails
    run_op(OP_LOAD, 5'd4, 32'h3A5, 32'h0, 32'h30, 32'h0, T - 1, 32'hA5A5, 1'b0);
    check("edge_ok_err_lit", obs_err, 1'b0);
    run_op(OP_LOAD, 5'd4, 32'h3A5, 32'h0, 32'h30, 32'h0, T, 32'hA5A5, 1'b0);
    check("edge_to_err_lit", obs_err, 1'b1);
    check("edge_to_rf_cnt_lit", obs_rf_cnt, 0);
    // err clears on the next accepted operation
    run_op(OP_STORE, 5'd2, 32'h10, 32'h0, 32'h40, 32'h77, 0, 32'h0, 1'b1);
    check("err_clear_lit", obs_err, 1'b0);

    // Jump-register and PC wrap-around
    run_op(OP_JR, 5'd5, 32'h0, 32'h0, 32'h50, 32'h1234, 0, 32'h0, 1'b1);
    check("jr_pc_lit", obs_pc, 32'h1234);
    run_op(OP_NOP, 5'd5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 0, 32'h0, 1'b0);
    check("pc_wrap_lit", obs_pc, 32'h0);

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      run_op(3'($urandom_range(0, 7)), REG_AW'($urandom), $urandom, $urandom, $urandom,
             $urandom, int'($urandom_range(0, T + 3)), $urandom, 1'($urandom));
    end

    // Reset in the middle of a load request
    opCode = OP_LOAD; RDadd = 5'd6; ALUres = 32'h2AA; PCold = 32'h200;
    RDold = 32'h99; ADDout = 32'h0;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("mid_mem_req", mem_req, 1'b1);
    resetIn = 1'b0;
    #1;
    check_reset_values("mid_rst");
    enable = 1'b0;
    tick();
    resetIn = 1'b1;
    tick();
    run_op(OP_ALU, 5'd12, 32'h600D, 32'h0, 32'h300, 32'h0, 0, 32'h0, 1'b1);
    check("post_rst_pc_lit", obs_pc, 32'h301);
    check("post_rst_data_lit", obs_rf_data, 32'h600D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
